pc_sequencer: RTL and testbench

- Parametrised successor to the single-cycle program counter. Holds the fetch address and selects the next PC each cycle from these sources: sequential, branch, jump, return-address stack (RAS) pop, exception vector and exception return.
- Adds a stall hold, a RAS for call/return, and an EPC register.
- Sits between the control unit / branch adder and instruction memory in the MIPS datapath.

---
 rtl/pc_sequencer.sv | 146 ++++++++++++++
 tb/tb_pc_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Program-counter sequencer for the MIPS fetch stage. Holds the
//               fetch address and picks the next PC each cycle from
//               sequential, branch, jump, return-address-stack pop, exception
//               vector and exception return sources. Includes a stall hold,
//               a circular return-address stack (RAS) and an EPC register.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               stall             - hold all state (reset still wins)
//               jump, pc_src      - take jump_address / branch_address
//               jump_address      - jump target (also ret target when empty)
//               branch_address    - taken-branch target
//               call, ret         - push pc_out+4 / pop RAS top as target
//               exception, eret   - trap to EXC_VECTOR / return to epc_out
//               pc_out, pc_plus4  - current fetch address and its successor
//               epc_out           - saved exception PC
//               ras_empty/full    - stack occupancy
//               ras_overflow/underflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080),
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] jump_address,
  input  logic [WIDTH-1:0] branch_address,
  input  logic             call,
  input  logic             ret,
  input  logic             exception,
  input  logic             eret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_overflow,
  output logic             ras_underflow
);

  localparam int unsigned      PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] epc;
  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0] top;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic             underflow;

  logic             ras_active;
  logic             do_push;
  logic             do_pop;
  logic             pop_ok;
  logic [PTR_W-1:0] top_after_pop;
  logic [CNT_W-1:0] cnt_after_pop;
  logic [PTR_W-1:0] push_idx;
  logic [WIDTH-1:0] ras_target;
  logic [WIDTH-1:0] next_raw;
  logic [WIDTH-1:0] next_pc;

  assign pc_plus4 = pc + WIDTH'(4);

  // Stack ops are modelled as "pop, then push": with call+ret together the
  // push lands in the slot the pop just vacated, so the count is unchanged.
  always_comb begin
    ras_active    = !exception && !eret;
    do_pop        = ras_active && ret;
    do_push       = ras_active && call;
    pop_ok        = do_pop && (count != '0);
    top_after_pop = pop_ok ? (top - PTR_ONE) : top;
    cnt_after_pop = pop_ok ? (count - CNT_ONE) : count;
    push_idx      = top_after_pop + PTR_ONE;
    // An empty-stack return falls back to the jump target.
    ras_target    = (count != '0) ? stack[top] : jump_address;
  end

  always_comb begin
    next_raw = pc_plus4;
    if (exception)   next_raw = EXC_VECTOR;
    else if (eret)   next_raw = epc;
    else if (ret)    next_raw = ras_target;
    else if (jump)   next_raw = jump_address;
    else if (pc_src) next_raw = branch_address;
    next_pc = {next_raw[WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      epc       <= '0;
      top       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!stall) begin
      pc <= next_pc;
      if (exception) begin
        epc <= pc;
      end
      if (do_push) begin
        // When already full, top+1 is the oldest slot: it is overwritten.
        top <= push_idx;
        if (cnt_after_pop == CNT_FULL) begin
          count    <= cnt_after_pop;
          overflow <= 1'b1;
        end else begin
          count <= cnt_after_pop + CNT_ONE;
        end
      end else begin
        top   <= top_after_pop;
        count <= cnt_after_pop;
      end
      if (do_pop && (count == '0)) begin
        underflow <= 1'b1;
      end
    end
  end

  // Stack contents carry no reset value; they are only written by a push.
  always_ff @(posedge clk) begin
    if (!reset && !stall && do_push) begin
      stack[push_idx] <= pc_plus4;
    end
  end

  assign pc_out        = pc;
  assign epc_out       = epc;
  assign ras_empty     = (count == '0);
  assign ras_full      = (count == CNT_FULL);
  assign ras_overflow  = overflow;
  assign ras_underflow = underflow;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer (WIDTH=32, RAS_DEPTH=4).
//               Directed vector table, hand-written corner sequences, and a
//               randomized run against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, stall, jump, pc_src, call, ret, exception, eret;
  logic [31:0] jump_address, branch_address;
  logic [31:0] pc_out, pc_plus4, epc_out;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  pc_sequencer #(
    .WIDTH        (32),
    .RESET_VECTOR (32'h0000_0000),
    .EXC_VECTOR   (32'h0000_0080),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .jump           (jump),
    .pc_src         (pc_src),
    .jump_address   (jump_address),
    .branch_address (branch_address),
    .call           (call),
    .ret            (ret),
    .exception      (exception),
    .eret           (eret),
    .pc_out         (pc_out),
    .pc_plus4       (pc_plus4),
    .epc_out        (epc_out),
    .ras_empty      (ras_empty),
    .ras_full       (ras_full),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: the RAS is a plain queue of return addresses.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_q [$];
  logic        m_ovf, m_unf;

  // ctrl bit order: {reset, stall, exception, eret, ret, call, jump, pc_src}
  localparam logic [7:0] C_RST = 8'h80, C_STL = 8'h40, C_EXC = 8'h20,
                         C_ERT = 8'h10, C_RET = 8'h08, C_CAL = 8'h04,
                         C_JMP = 8'h02, C_BR  = 8'h01, C_NONE = 8'h00;

  typedef struct {
    logic [7:0]  ctrl;
    logic [31:0] ja;
    logic [31:0] ba;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic [3:0]  exp_flags;  // {empty, full, overflow, underflow}
  } vec_t;

  vec_t vecs [27];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {28'd0, ras_empty, ras_full, ras_overflow, ras_underflow};
  endfunction

  task automatic model_step(input logic [7:0] c, input logic [31:0] ja, input logic [31:0] ba);
    logic [31:0] nxt, tgt;
    if (c[7]) begin
      m_pc = 32'h0; m_epc = 32'h0; m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else if (!c[6]) begin
      tgt = ja;
      if (c[5]) begin
        nxt   = 32'h80;
        m_epc = m_pc;
      end else if (c[4]) begin
        nxt = m_epc;
      end else begin
        if (c[3]) begin
          if (m_q.size() > 0) tgt = m_q.pop_back();
          else m_unf = 1'b1;
        end
        if (c[2]) begin
          m_q.push_back(m_pc + 32'd4);
          if (m_q.size() > DEPTH) begin
            void'(m_q.pop_front());
            m_ovf = 1'b1;
          end
        end
        if (c[3])      nxt = tgt;
        else if (c[1]) nxt = ja;
        else if (c[0]) nxt = ba;
        else           nxt = m_pc + 32'd4;
      end
      m_pc = nxt & 32'hFFFF_FFFC;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 ns past the edge.
  task automatic apply(input logic [7:0] c, input logic [31:0] ja, input logic [31:0] ba);
    {reset, stall, exception, eret, ret, call, jump, pc_src} = c;
    jump_address   = ja;
    branch_address = ba;
    model_step(c, ja, ba);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input int i);
    chk($sformatf("rnd%0d pc", i), pc_out, m_pc);
    chk($sformatf("rnd%0d pc_plus4", i), pc_plus4, m_pc + 32'd4);
    chk($sformatf("rnd%0d epc", i), epc_out, m_epc);
    chk($sformatf("rnd%0d flags", i), flags(),
        {28'd0, m_q.size() == 0, m_q.size() == DEPTH, m_ovf, m_unf});
  endtask

  function automatic vec_t mk(input logic [7:0] c, input logic [31:0] ja, input logic [31:0] ba,
                              input logic [31:0] p, input logic [31:0] e, input logic [3:0] f);
    vec_t v;
    v.ctrl = c; v.ja = ja; v.ba = ba; v.exp_pc = p; v.exp_epc = e; v.exp_flags = f;
    return v;
  endfunction

  initial begin
    {reset, stall, exception, eret, ret, call, jump, pc_src} = '0;
    jump_address = '0; branch_address = '0;
    m_pc = '0; m_epc = '0; m_ovf = 1'b0; m_unf = 1'b0;

    // Reset, free-run, priority, exception/eret, stall, RAS fill/overflow/drain, underflow, alignment
    vecs[0]  = mk(C_RST,           0,       0,     32'h000, 32'h00, 4'b1000);
    vecs[1]  = mk(C_NONE,          0,       0,     32'h004, 32'h00, 4'b1000);
    vecs[2]  = mk(C_NONE,          0,       0,     32'h008, 32'h00, 4'b1000);
    vecs[3]  = mk(C_NONE,          0,       0,     32'h00C, 32'h00, 4'b1000);
    vecs[4]  = mk(C_NONE,          0,       0,     32'h010, 32'h00, 4'b1000);
    vecs[5]  = mk(C_JMP|C_BR,      32'h200, 32'h100, 32'h200, 32'h00, 4'b1000);
    vecs[6]  = mk(C_JMP,           32'h010, 0,     32'h010, 32'h00, 4'b1000);
    vecs[7]  = mk(C_EXC|C_JMP|C_BR, 32'h200, 32'h100, 32'h080, 32'h10, 4'b1000);
    vecs[8]  = mk(C_ERT,           0,       0,     32'h010, 32'h10, 4'b1000);
    vecs[9]  = mk(C_JMP,           32'h020, 0,     32'h020, 32'h10, 4'b1000);
    vecs[10] = mk(C_STL|C_JMP|C_CAL, 32'h300, 0,   32'h020, 32'h10, 4'b1000);
    vecs[11] = mk(C_STL|C_JMP|C_CAL, 32'h300, 0,   32'h020, 32'h10, 4'b1000);
    vecs[12] = mk(C_STL|C_JMP|C_CAL, 32'h300, 0,   32'h020, 32'h10, 4'b1000);
    vecs[13] = mk(C_NONE,          0,       0,     32'h024, 32'h10, 4'b1000);
    vecs[14] = mk(C_JMP,           32'h000, 0,     32'h000, 32'h10, 4'b1000);
    vecs[15] = mk(C_CAL|C_JMP,     32'h100, 0,     32'h100, 32'h10, 4'b0000);
    vecs[16] = mk(C_CAL|C_JMP,     32'h200, 0,     32'h200, 32'h10, 4'b0000);
    vecs[17] = mk(C_CAL|C_JMP,     32'h300, 0,     32'h300, 32'h10, 4'b0000);
    vecs[18] = mk(C_CAL|C_JMP,     32'h400, 0,     32'h400, 32'h10, 4'b0100);
    vecs[19] = mk(C_CAL|C_JMP,     32'h500, 0,     32'h500, 32'h10, 4'b0110);
    vecs[20] = mk(C_RET,           32'h3C0, 0,     32'h404, 32'h10, 4'b0010);
    vecs[21] = mk(C_RET,           32'h3C0, 0,     32'h304, 32'h10, 4'b0010);
    vecs[22] = mk(C_RET,           32'h3C0, 0,     32'h204, 32'h10, 4'b0010);
    vecs[23] = mk(C_RET,           32'h3C0, 0,     32'h104, 32'h10, 4'b1010);
    vecs[24] = mk(C_RET,           32'h3C0, 0,     32'h3C0, 32'h10, 4'b1011);
    vecs[25] = mk(C_NONE,          0,       0,     32'h3C4, 32'h10, 4'b1011);
    vecs[26] = mk(C_JMP,           32'h203, 0,     32'h200, 32'h10, 4'b1011);

    for (int i = 0; i < 27; i++) begin
      apply(vecs[i].ctrl, vecs[i].ja, vecs[i].ba);
      chk($sformatf("vec%0d pc", i), pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d epc", i), epc_out, vecs[i].exp_epc);
      chk($sformatf("vec%0d flags", i), flags(), {28'd0, vecs[i].exp_flags});
    end

    // Reset wins over stall and clears sticky flags and EPC.
    apply(C_JMP, 32'h040, 0);
    chk("pre_rst pc", pc_out, 32'h040);
    apply(C_RST|C_STL|C_JMP, 32'h300, 0);
    chk("rst_stall pc", pc_out, 32'h000);
    chk("rst_stall epc", epc_out, 32'h000);
    chk("rst_stall flags", flags(), 32'h8);

    // Address wrap modulo 2^32.
    apply(C_JMP, 32'hFFFF_FFFC, 0);
    chk("wrap pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap pc_plus4", pc_plus4, 32'h0);
    apply(C_NONE, 0, 0);
    chk("wrap next", pc_out, 32'h0);

    // call+ret together: pop supplies target, push refills the slot.
    apply(C_JMP, 32'h100, 0);
    apply(C_CAL|C_JMP, 32'h500, 0);
    chk("cr_setup pc", pc_out, 32'h500);
    apply(C_CAL|C_RET, 32'h700, 0);
    chk("callret pc", pc_out, 32'h104);
    chk("callret flags", flags(), 32'h0);
    apply(C_RET, 32'h700, 0);
    chk("callret top", pc_out, 32'h504);
    chk("callret empty", flags(), 32'h8);

    // exception + eret + call: exception wins and the RAS is untouched.
    apply(C_EXC|C_ERT|C_CAL, 0, 0);
    chk("exc_eret pc", pc_out, 32'h080);
    chk("exc_eret epc", epc_out, 32'h504);
    chk("exc_eret flags", flags(), 32'h8);

    // Randomized run against the reference model.
    apply(C_RST, 0, 0);
    check_model(-1);
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      c[7] = ($urandom_range(0, 63) == 0);
      c[6] = ($urandom_range(0, 3) == 0);
      c[5] = ($urandom_range(0, 15) == 0);
      c[4] = ($urandom_range(0, 11) == 0);
      c[3] = ($urandom_range(0, 3) == 0);
      c[2] = ($urandom_range(0, 3) == 0);
      c[1] = ($urandom_range(0, 2) == 0);
      c[0] = ($urandom_range(0, 3) == 0);
      apply(c, $urandom, $urandom);
      check_model(i);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
